bus_arb: RTL and testbench

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb.sv | 131 +++++++++++++
 tb/tb_bus_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb.sv
// Four-master round-robin burst arbiter: one ARB clock per decision, bursts of up to 15 beats.
// Optional per-master wait monitor with starvation flags is enabled by defining BUS_ARB_WAIT_MON_EN.
module bus_arb #(
   parameter int NM         = 4,
   parameter int STARVE_LIM = 48
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4*NM-1:0] req,
   input  logic [NM-1:0]   xfr,
   output logic [NM-1:0]   grant,
   output logic [1:0]      owner,
   output logic            busy
`ifdef BUS_ARB_WAIT_MON_EN
   ,
   output logic [NM-1:0]   starve
`endif
);

   if (NM != 4 || STARVE_LIM < 1) begin : g_cfg_err
      $error("bus_arb supports NM=4 and STARVE_LIM>=1 only");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARB   = 2'd1,
      S_BURST = 2'd2
   } state_t;

   state_t     r_state, w_state_next;
   logic [1:0] r_owner, w_owner_next;
   logic [1:0] r_last, w_last_next;
   logic [3:0] r_cnt, w_cnt_next;
   logic [1:0] w_win;
   logic       w_win_vld;
   logic [3:0] w_req_win;
   logic       w_any;

   assign w_any = |xfr;

   // Descending scan so the lowest offset from last owner (highest priority) is written last.
   always_comb begin
      w_win     = 2'd0;
      w_win_vld = 1'b0;
      for (int k = NM; k >= 1; k--) begin
         if (xfr[2'(r_last + 2'(k))]) begin
            w_win     = 2'(r_last + 2'(k));
            w_win_vld = 1'b1;
         end
      end
   end

   assign w_req_win = req[{w_win, 2'b00} +: 4];

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_last_next  = r_last;
      w_cnt_next   = r_cnt;
      grant        = '0;
      case (r_state)
         S_IDLE: begin
            if (w_any) w_state_next = S_ARB;
         end
         S_ARB: begin
            if (w_win_vld) begin
               w_state_next = S_BURST;
               w_owner_next = w_win;
               w_last_next  = w_win;
               w_cnt_next   = (w_req_win == 4'd0) ? 4'd1 : w_req_win;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_BURST: begin
            grant[r_owner] = xfr[r_owner];
            if (!xfr[r_owner]) begin
               // Owner abandoned the burst: no beat this clock.
               w_state_next = w_any ? S_ARB : S_IDLE;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
               if (r_cnt == 4'd1) w_state_next = w_any ? S_ARB : S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_owner <= 2'd0;
         r_last  <= 2'd3;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_owner <= w_owner_next;
         r_last  <= w_last_next;
         r_cnt   <= w_cnt_next;
      end
   end

   assign busy  = (r_state == S_BURST);
   assign owner = busy ? r_owner : 2'd0;

`ifdef BUS_ARB_WAIT_MON_EN
   for (genvar gi = 0; gi < NM; gi++) begin : g_wait
      logic [7:0] r_wait, w_wait_next;
      logic       r_starve;

      always_comb begin
         w_wait_next = 8'd0;
         if (xfr[gi] && !grant[gi])
            w_wait_next = (r_wait == 8'hFF) ? 8'hFF : r_wait + 8'd1;
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_wait   <= 8'd0;
            r_starve <= 1'b0;
         end else begin
            r_wait   <= w_wait_next;
            r_starve <= (int'(w_wait_next) >= STARVE_LIM);
         end
      end

      assign starve[gi] = r_starve;
   end
`endif

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: directed scenarios plus randomized traffic against a
// cycle-level behavioural reference model.
module tb_bus_arb;
   localparam int LIM = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic [3:0]  xfr;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        busy;
`ifdef BUS_ARB_WAIT_MON_EN
   logic [3:0]  starve;
`endif

   bus_arb #(.NM(4), .STARVE_LIM(LIM)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .xfr   (xfr),
      .grant (grant),
      .owner (owner),
      .busy  (busy)
`ifdef BUS_ARB_WAIT_MON_EN
      ,
      .starve(starve)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: beats left in the current burst (0 = no burst), pending decision flag.
   int m_left, m_owner, m_last;
   bit m_arb;
   int m_wait[4];
   bit m_starve[4];

   int lat[4];
   bit lat_en;
   int own_q[$];
   int beat_q[$];
   bit prev_busy;
   logic [3:0] last_grant;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int beats_of(input logic [15:0] rq, input int m);
      int b;
      b = int'(rq[4*m +: 4]);
      return (b == 0) ? 1 : b;
   endfunction

   task automatic model_reset();
      m_left = 0; m_owner = 0; m_last = 3; m_arb = 0;
      for (int i = 0; i < 4; i++) begin
         m_wait[i] = 0; m_starve[i] = 0; lat[i] = 0;
      end
      prev_busy = 0;
      last_grant = '0;
   endtask

   task automatic model_clk();
      for (int i = 0; i < 4; i++) begin
         bit g;
         g = (m_left > 0) && (m_owner == i) && xfr[i];
         if (xfr[i] && !g) m_wait[i] = (m_wait[i] >= 255) ? 255 : m_wait[i] + 1;
         else m_wait[i] = 0;
         m_starve[i] = (m_wait[i] >= LIM);
      end
      if (m_left > 0) begin
         if (!xfr[m_owner]) begin
            m_left = 0;
            m_arb = |xfr;
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_arb = |xfr;
         end
      end else if (m_arb) begin
         m_arb = 0;
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (xfr[c]) begin
               m_owner = c; m_last = c; m_left = beats_of(req, c);
               break;
            end
         end
      end else begin
         m_arb = |xfr;
      end
   endtask

   task automatic observe();
      logic [3:0] eg;
      bit eb;
      eb = (m_left > 0);
      eg = (eb && xfr[m_owner]) ? (4'b0001 << m_owner) : 4'b0000;
      chk("grant", grant, eg);
      chk("busy", busy, eb);
      chk("owner", owner, eb ? m_owner : 0);
      chk("onehot", $countones(grant) <= 1, 1);
`ifdef BUS_ARB_WAIT_MON_EN
      for (int i = 0; i < 4; i++) chk("starve", starve[i], m_starve[i]);
`endif
      if (busy && !prev_busy) begin
         own_q.push_back(int'(owner));
         beat_q.push_back(0);
         $display("burst start master=%0d t=%0t", owner, $time);
      end
      if (grant != 4'b0000 && beat_q.size() > 0) beat_q[beat_q.size()-1] += 1;
      prev_busy = busy;
      for (int i = 0; i < 4; i++) begin
         if (grant[i]) begin
            if (lat_en) begin
               checks++;
               assert (lat[i] <= 49) else begin
                  failures++;
                  $error("FAIL latency master=%0d observed=%0d required<=49", i, lat[i]);
               end
            end
            lat[i] = 0;
         end else if (xfr[i]) lat[i]++;
         else lat[i] = 0;
      end
      last_grant = grant;
   endtask

   task automatic step(input logic [15:0] rq, input logic [3:0] xf);
      req = rq; xfr = xf;
      #1 observe();
      @(posedge clk);
      model_clk();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; xfr = '0; req = '0;
      model_reset();
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
`ifdef BUS_ARB_WAIT_MON_EN
      chk("rst_starve", starve, 0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      own_q.delete();
      beat_q.delete();
   endtask

   initial begin
      logic [3:0]  xv;
      logic [15:0] rv;
      rst = 1'b0; xfr = '0; req = '0;
      lat_en = 0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Single master, 15-beat bursts back to back.
      repeat (40) step(16'h000F, 4'b0001);
      chk("r27_nbursts", own_q.size(), 3);
      if (own_q.size() >= 2) begin
         chk("r27_len0", beat_q[0], 15);
         chk("r27_len1", beat_q[1], 15);
         chk("r27_own1", own_q[1], 0);
      end
      repeat (3) step(16'h0000, 4'b0000);

      // All four request at once, 2 beats each.
      do_reset();
      repeat (16) step(16'h2222, 4'b1111);
      chk("r28_nbursts", own_q.size(), 5);
      for (int i = 0; i < 5 && i < own_q.size(); i++) begin
         chk("r28_order", own_q[i], i % 4);
         chk("r28_len", beat_q[i], 2);
      end
      repeat (3) step(16'h0000, 4'b0000);

      // Owner 2 abandons an 8-beat burst after 3 beats.
      do_reset();
      repeat (5) step(16'h0800, 4'b0100);
      step(16'h0800, 4'b0001);
      #1;
      chk("r30_arb_busy", busy, 0);
      chk("r30_arb_grant", grant, 0);
      repeat (4) step(16'h0800, 4'b0001);
      chk("r30_owner", own_q.size() > 0 ? own_q[0] : -1, 2);
      chk("r30_beats", beat_q.size() > 0 ? beat_q[0] : -1, 3);
      repeat (3) step(16'h0000, 4'b0000);

      // Asynchronous reset during beat 5 of a 10-beat burst.
      do_reset();
      repeat (6) step(16'h000A, 4'b0001);
      req = 16'h000A; xfr = 4'b0001;
      #1 chk("r31_beat5", grant, 4'b0001);
      #1 rst = 1'b0;
      #1;
      chk("r31_async_grant", grant, 0);
      chk("r31_async_busy", busy, 0);
      chk("r31_async_owner", owner, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      own_q.delete(); beat_q.delete();
      repeat (6) step(16'h1111, 4'b1111);
      chk("r31_first_owner", own_q.size() > 0 ? own_q[0] : -1, 0);
      repeat (3) step(16'h0000, 4'b0000);

`ifdef BUS_ARB_WAIT_MON_EN
      // Master 1 waits behind a 15-beat burst from master 0.
      do_reset();
      repeat (9) step(16'h001F, 4'b0011);
      #1 chk("r32_starve_pre", starve[1], 0);
      step(16'h001F, 4'b0011);
      #1 chk("r32_starve_set", starve[1], 1);
      repeat (20) step(16'h001F, 4'b0011);
      repeat (3) step(16'h0000, 4'b0000);
`endif

      // Master 0 streams 15-beat bursts; masters 1..3 make short random requests.
      do_reset();
      lat_en = 1;
      xv = 4'b0001; rv = 16'h000F;
      repeat (600) begin
         step(rv, xv);
         for (int i = 1; i < 4; i++) begin
            if (xv[i] && last_grant[i]) xv[i] = 1'b0;
            else if (!xv[i] && $urandom_range(0, 9) == 0) begin
               xv[i] = 1'b1;
               rv[4*i +: 4] = 4'($urandom_range(0, 1));
            end
         end
      end
      lat_en = 0;
      repeat (3) step(16'h0000, 4'b0000);

      // Fully random traffic with req changing every clock.
      do_reset();
      xv = '0;
      repeat (800) begin
         step(16'($urandom), xv);
         for (int i = 0; i < 4; i++) begin
            if (xv[i] && last_grant[i]) begin
               if ($urandom_range(0, 5) == 0) xv[i] = 1'b0;
            end else if (!xv[i] && $urandom_range(0, 4) == 0) xv[i] = 1'b1;
         end
      end
      repeat (3) step(16'h0000, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
